// File: rtl/instr_reg_pkg.sv
// Shared types, constants and width helpers for the multi-byte instruction register
// and the control-unit sequencer that reuses its length decode.
package instr_reg_pkg;

  typedef logic [1:0] ir_state_t;

  localparam ir_state_t ST_EMPTY = 2'd0;
  localparam ir_state_t ST_FETCH = 2'd1;
  localparam ir_state_t ST_FULL  = 2'd2;

  // Wide enough for OPC_W up to 8; users slice the low 2*2^OPC_W bits.
  localparam int unsigned                LEN_MAP_MAX_W = 512;
  localparam logic [LEN_MAP_MAX_W-1:0]   LEN_MAP_DEF   = '0;

  function automatic int sel_w(input int max_bytes);
    return (max_bytes > 1) ? $clog2(max_bytes) : 1;
  endfunction

  function automatic int len_w(input int max_bytes);
    return $clog2(max_bytes + 1);
  endfunction

  // Operand storage slots; a 1-byte-only build keeps one dead slot to avoid a zero-width port.
  function automatic int ext_slots(input int max_bytes);
    return (max_bytes > 1) ? max_bytes - 1 : 1;
  endfunction

  function automatic logic [1:0] clamp_ext(input logic [1:0] raw, input int max_bytes);
    logic [1:0] lim;
    lim = 2'(max_bytes - 1);
    return (raw > lim) ? lim : raw;
  endfunction

endpackage

// File: rtl/instr_reg_multi_if.sv
// Shared-bus side of the instruction register: load/drive strobes, operand select and bus data.
interface instr_reg_multi_if
  import instr_reg_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int MAX_BYTES = 3
);
  localparam int SEL_W = sel_w(MAX_BYTES);

  logic [DATA_W-1:0] bus_in;
  logic [DATA_W-1:0] bus_out;
  logic              bus_oe;
  logic              ii_n;
  logic              io_n;
  logic [SEL_W-1:0]  oper_sel;

  modport master (output bus_in, ii_n, io_n, oper_sel, input  bus_out, bus_oe);
  modport slave  (input  bus_in, ii_n, io_n, oper_sel, output bus_out, bus_oe);
endinterface

// File: rtl/instr_len_decode.sv
// Opcode -> extension-byte count (clamped to the configured maximum) and total length.
module instr_len_decode
  import instr_reg_pkg::*;
#(
  parameter int                        OPC_W     = 4,
  parameter int                        MAX_BYTES = 3,
  parameter logic [2*(2**OPC_W)-1:0]   LEN_MAP   = LEN_MAP_DEF[2*(2**OPC_W)-1:0],
  localparam int                       LEN_W     = len_w(MAX_BYTES)
) (
  input  logic [OPC_W-1:0] opc_i,
  output logic [1:0]       ext_o,
  output logic [LEN_W-1:0] len_o
);
  logic [1:0] raw;

  assign raw   = LEN_MAP[{opc_i, 1'b0} +: 2];
  assign ext_o = clamp_ext(raw, MAX_BYTES);
  assign len_o = LEN_W'(ext_o) + LEN_W'(1);
endmodule

// File: rtl/instr_reg_multi.sv
// Instruction register: assembles 1..MAX_BYTES instruction bytes from the shared bus and
// drives the selected operand field back onto it.
module instr_reg_multi
  import instr_reg_pkg::*;
#(
  parameter int                        DATA_W    = 8,
  parameter int                        OPC_W     = 4,
  parameter int                        MAX_BYTES = 3,
  parameter logic [2*(2**OPC_W)-1:0]   LEN_MAP   = LEN_MAP_DEF[2*(2**OPC_W)-1:0],
  localparam int                       IMM_W     = DATA_W - OPC_W,
  localparam int                       SLOTS     = ext_slots(MAX_BYTES),
  localparam int                       OPND_W    = SLOTS * DATA_W,
  localparam int                       LEN_W     = len_w(MAX_BYTES)
) (
  input  logic                clk,
  input  logic                clr_n,
  input  logic                flush,
  instr_reg_multi_if.slave    bus,
  output logic [OPC_W-1:0]    opcode,
  output logic [IMM_W-1:0]    imm,
  output logic [OPND_W-1:0]   operand,
  output logic [LEN_W-1:0]    instr_len,
  output logic                instr_valid,
  output logic                fetch_more,
  output logic                conflict
);
  ir_state_t         state_q,   state_d;
  logic [OPC_W-1:0]  opcode_q,  opcode_d;
  logic [IMM_W-1:0]  imm_q,     imm_d;
  logic [OPND_W-1:0] operand_q, operand_d;
  logic [LEN_W-1:0]  len_q,     len_d;
  logic [1:0]        ext_q,     ext_d;
  logic [1:0]        cnt_q,     cnt_d;
  logic              valid_q,   valid_d;
  logic              fetch_q,   fetch_d;
  logic              conflict_q, conflict_d;

  logic [1:0]        new_ext;
  logic [LEN_W-1:0]  new_len;
  logic [DATA_W-1:0] bus_out_c;

  // Decode the incoming byte so a byte-0 load knows its length in the same cycle.
  instr_len_decode #(
    .OPC_W     (OPC_W),
    .MAX_BYTES (MAX_BYTES),
    .LEN_MAP   (LEN_MAP)
  ) u_len_dec (
    .opc_i (bus.bus_in[DATA_W-1 -: OPC_W]),
    .ext_o (new_ext),
    .len_o (new_len)
  );

  always_comb begin
    state_d    = state_q;
    opcode_d   = opcode_q;
    imm_d      = imm_q;
    operand_d  = operand_q;
    len_d      = len_q;
    ext_d      = ext_q;
    cnt_d      = cnt_q;
    conflict_d = ~bus.ii_n & ~bus.io_n;
    if (flush) begin
      state_d    = ST_EMPTY;
      opcode_d   = '0;
      imm_d      = '0;
      operand_d  = '0;
      len_d      = '0;
      ext_d      = '0;
      cnt_d      = '0;
      conflict_d = 1'b0;
    end else if (!bus.ii_n) begin
      if (state_q == ST_FETCH) begin
        for (int k = 0; k < SLOTS; k++)
          if (cnt_q == 2'(k)) operand_d[k*DATA_W +: DATA_W] = bus.bus_in;
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == ext_q - 2'd1) state_d = ST_FULL;
      end else begin
        // EMPTY or FULL: this byte starts a new instruction; stale operands are wiped.
        opcode_d  = bus.bus_in[DATA_W-1 -: OPC_W];
        imm_d     = bus.bus_in[IMM_W-1:0];
        operand_d = '0;
        cnt_d     = '0;
        ext_d     = new_ext;
        len_d     = new_len;
        state_d   = (new_ext == 2'd0) ? ST_FULL : ST_FETCH;
      end
    end
    valid_d = (state_d == ST_FULL);
    fetch_d = (state_d == ST_FETCH);
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q    <= ST_EMPTY;
      opcode_q   <= '0;
      imm_q      <= '0;
      operand_q  <= '0;
      len_q      <= '0;
      ext_q      <= '0;
      cnt_q      <= '0;
      valid_q    <= 1'b0;
      fetch_q    <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      opcode_q   <= opcode_d;
      imm_q      <= imm_d;
      operand_q  <= operand_d;
      len_q      <= len_d;
      ext_q      <= ext_d;
      cnt_q      <= cnt_d;
      valid_q    <= valid_d;
      fetch_q    <= fetch_d;
      conflict_q <= conflict_d;
    end
  end

  // Field select is independent of state; unloaded or out-of-range bytes read as zero.
  always_comb begin
    bus_out_c = '0;
    if (int'(bus.oper_sel) == 0) bus_out_c = DATA_W'(imm_q);
    for (int k = 1; k < MAX_BYTES; k++)
      if (int'(bus.oper_sel) == k) bus_out_c = operand_q[(k-1)*DATA_W +: DATA_W];
  end

  assign bus.bus_out  = bus_out_c;
  assign bus.bus_oe   = ~bus.io_n & clr_n;

  assign opcode      = opcode_q;
  assign imm         = imm_q;
  assign operand     = operand_q;
  assign instr_len   = len_q;
  assign instr_valid = valid_q;
  assign fetch_more  = fetch_q;
  assign conflict    = conflict_q;
endmodule

// File: tb/tb_instr_reg_multi.sv
// Bench for instr_reg_multi: three configurations share one stimulus stream; directed table,
// hand sequences and a randomized phase against a byte-list reference model.
module tb_instr_reg_multi;
  localparam logic [31:0] MAP_A = 32'h0;
  localparam logic [31:0] MAP_B = (32'd2 << 20) | (32'd1 << 6) | (32'd3 << 14) | (32'd1 << 24);
  localparam logic [31:0] MAP_C = (32'd3 << 20) | (32'd1 << 8);

  logic       clk = 1'b0;
  logic       clr_n, flush, ii_n, io_n;
  logic [1:0] sel;
  logic [7:0] bus_in;

  always #5 clk = ~clk;

  instr_reg_multi_if #(.DATA_W(8), .MAX_BYTES(3)) ifa ();
  instr_reg_multi_if #(.DATA_W(8), .MAX_BYTES(3)) ifb ();
  instr_reg_multi_if #(.DATA_W(8), .MAX_BYTES(2)) ifc ();

  assign ifa.bus_in = bus_in; assign ifa.ii_n = ii_n; assign ifa.io_n = io_n; assign ifa.oper_sel = sel;
  assign ifb.bus_in = bus_in; assign ifb.ii_n = ii_n; assign ifb.io_n = io_n; assign ifb.oper_sel = sel;
  assign ifc.bus_in = bus_in; assign ifc.ii_n = ii_n; assign ifc.io_n = io_n; assign ifc.oper_sel = sel[0];

  logic [3:0] opc_a, opc_b, opc_c, imm_a, imm_b, imm_c;
  logic [15:0] opnd_a, opnd_b;
  logic [7:0]  opnd_c;
  logic [1:0]  len_a, len_b, len_c;
  logic        vld_a, vld_b, vld_c, fm_a, fm_b, fm_c, cf_a, cf_b, cf_c;

  instr_reg_multi #(.DATA_W(8), .OPC_W(4), .MAX_BYTES(3)) u_a (
    .clk(clk), .clr_n(clr_n), .flush(flush), .bus(ifa), .opcode(opc_a), .imm(imm_a),
    .operand(opnd_a), .instr_len(len_a), .instr_valid(vld_a), .fetch_more(fm_a), .conflict(cf_a));
  instr_reg_multi #(.DATA_W(8), .OPC_W(4), .MAX_BYTES(3), .LEN_MAP(MAP_B)) u_b (
    .clk(clk), .clr_n(clr_n), .flush(flush), .bus(ifb), .opcode(opc_b), .imm(imm_b),
    .operand(opnd_b), .instr_len(len_b), .instr_valid(vld_b), .fetch_more(fm_b), .conflict(cf_b));
  instr_reg_multi #(.DATA_W(8), .OPC_W(4), .MAX_BYTES(2), .LEN_MAP(MAP_C)) u_c (
    .clk(clk), .clr_n(clr_n), .flush(flush), .bus(ifc), .opcode(opc_c), .imm(imm_c),
    .operand(opnd_c), .instr_len(len_c), .instr_valid(vld_c), .fetch_more(fm_c), .conflict(cf_c));

  int nvec = 0;
  int nbad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  // Reference model: the bytes of the current instruction in arrival order.
  logic [7:0] mby [3][4];
  int         mcnt [3];
  logic       mcf [3];
  int         lm [3][16];
  int         mbs [3];

  function automatic int need(input int d);
    int e;
    e = lm[d][mby[d][0][7:4]];
    if (e > mbs[d] - 1) e = mbs[d] - 1;
    return e + 1;
  endfunction

  task automatic model_step();
    for (int d = 0; d < 3; d++) begin
      if (!clr_n || flush) begin
        mcnt[d] = 0;
        mcf[d]  = 1'b0;
      end else begin
        mcf[d] = !ii_n && !io_n;
        if (!ii_n) begin
          if (mcnt[d] == 0 || mcnt[d] == need(d)) begin
            mby[d][0] = bus_in;
            mcnt[d]   = 1;
          end else begin
            mby[d][mcnt[d]] = bus_in;
            mcnt[d]++;
          end
        end
      end
    end
  endtask

  task automatic cmp_model(input int d);
    logic [3:0] o, im; logic [15:0] op; logic [1:0] ln; logic v, f, c, oe; logic [7:0] bo;
    logic [15:0] e_op; int s, e_len; logic [7:0] e_bo; string dn;
    case (d)
      0:       begin o = opc_a; im = imm_a; op = opnd_a; ln = len_a; v = vld_a; f = fm_a; c = cf_a; oe = ifa.bus_oe; bo = ifa.bus_out; dn = "A"; end
      1:       begin o = opc_b; im = imm_b; op = opnd_b; ln = len_b; v = vld_b; f = fm_b; c = cf_b; oe = ifb.bus_oe; bo = ifb.bus_out; dn = "B"; end
      default: begin o = opc_c; im = imm_c; op = {8'h0, opnd_c}; ln = len_c; v = vld_c; f = fm_c; c = cf_c; oe = ifc.bus_oe; bo = ifc.bus_out; dn = "C"; end
    endcase
    e_op = '0;
    for (int k = 1; k < mcnt[d]; k++) e_op[(k-1)*8 +: 8] = mby[d][k];
    e_len = (mcnt[d] > 0) ? need(d) : 0;
    s = (d == 2) ? int'(sel[0]) : int'(sel);
    e_bo = 8'h0;
    if (mcnt[d] > 0) begin
      if (s == 0) e_bo = {4'h0, mby[d][0][3:0]};
      else if (s < mbs[d] && s < mcnt[d]) e_bo = mby[d][s];
    end
    chk({dn, ".opcode"},  32'(o),  (mcnt[d] > 0) ? 32'(mby[d][0][7:4]) : 32'h0);
    chk({dn, ".imm"},     32'(im), (mcnt[d] > 0) ? 32'(mby[d][0][3:0]) : 32'h0);
    chk({dn, ".operand"}, 32'(op), 32'(e_op));
    chk({dn, ".len"},     32'(ln), 32'(e_len));
    chk({dn, ".valid"},   32'(v),  32'(mcnt[d] > 0 && mcnt[d] == e_len));
    chk({dn, ".fetch"},   32'(f),  32'(mcnt[d] > 0 && mcnt[d] < e_len));
    chk({dn, ".conflict"},32'(c),  32'(mcf[d]));
    chk({dn, ".bus_oe"},  32'(oe), 32'(!io_n && clr_n));
    chk({dn, ".bus_out"}, 32'(bo), 32'(e_bo));
  endtask

  task automatic apply(input logic c, input logic fl, input logic ii, input logic io,
                       input logic [1:0] s, input logic [7:0] b);
    clr_n = c; flush = fl; ii_n = ii; io_n = io; sel = s; bus_in = b;
    @(posedge clk);
    model_step();
    #1;
  endtask

  typedef struct {
    logic c, fl, ii, io; logic [1:0] s; logic [7:0] b;
    logic [3:0] opc, imm; logic [15:0] opnd; logic [1:0] len;
    logic vld, fm, cf, oe; logic [7:0] bo;
  } vec_t;
  vec_t tv[$];

  function automatic vec_t mk(input logic c, fl, ii, io, input logic [1:0] s, input logic [7:0] b,
                              input logic [3:0] opc, imm, input logic [15:0] opnd, input logic [1:0] len,
                              input logic vld, fm, cf, oe, input logic [7:0] bo);
    vec_t v;
    v.c = c; v.fl = fl; v.ii = ii; v.io = io; v.s = s; v.b = b;
    v.opc = opc; v.imm = imm; v.opnd = opnd; v.len = len;
    v.vld = vld; v.fm = fm; v.cf = cf; v.oe = oe; v.bo = bo;
    return v;
  endfunction

  initial begin
    clr_n = 1'b0; flush = 1'b0; ii_n = 1'b1; io_n = 1'b1; sel = 2'd0; bus_in = 8'h0;
    mbs[0] = 3; mbs[1] = 3; mbs[2] = 2;
    for (int n = 0; n < 16; n++) begin
      lm[0][n] = int'((MAP_A >> (2*n)) & 32'h3);
      lm[1][n] = int'((MAP_B >> (2*n)) & 32'h3);
      lm[2][n] = int'((MAP_C >> (2*n)) & 32'h3);
    end
    for (int d = 0; d < 3; d++) begin mcnt[d] = 0; mcf[d] = 1'b0; end

    // Directed vectors against configuration B (A->3 bytes, 3/C->2 bytes, 7 clamps to 3 bytes).
    tv.push_back(mk(0,0,1,0,0,8'hFF, 4'h0,4'h0,16'h0000,2'd0, 0,0,0,0,8'h00));
    tv.push_back(mk(0,0,1,0,0,8'hFF, 4'h0,4'h0,16'h0000,2'd0, 0,0,0,0,8'h00));
    for (int i = 0; i < 3; i++)
      tv.push_back(mk(1,0,1,1,0,8'h00, 4'h0,4'h0,16'h0000,2'd0, 0,0,0,0,8'h00));
    tv.push_back(mk(1,0,0,1,0,8'h2E, 4'h2,4'hE,16'h0000,2'd1, 1,0,0,0,8'h0E));
    tv.push_back(mk(1,0,1,0,0,8'h00, 4'h2,4'hE,16'h0000,2'd1, 1,0,0,1,8'h0E));
    tv.push_back(mk(1,0,0,1,0,8'hA3, 4'hA,4'h3,16'h0000,2'd3, 0,1,0,0,8'h03));
    tv.push_back(mk(1,0,1,1,0,8'h00, 4'hA,4'h3,16'h0000,2'd3, 0,1,0,0,8'h03));
    tv.push_back(mk(1,0,1,1,0,8'h00, 4'hA,4'h3,16'h0000,2'd3, 0,1,0,0,8'h03));
    tv.push_back(mk(1,0,0,1,0,8'h34, 4'hA,4'h3,16'h0034,2'd3, 0,1,0,0,8'h03));
    tv.push_back(mk(1,0,0,1,0,8'h12, 4'hA,4'h3,16'h1234,2'd3, 1,0,0,0,8'h03));
    tv.push_back(mk(1,0,1,0,2,8'h00, 4'hA,4'h3,16'h1234,2'd3, 1,0,0,1,8'h12));
    tv.push_back(mk(1,0,1,0,3,8'h00, 4'hA,4'h3,16'h1234,2'd3, 1,0,0,1,8'h00));
    tv.push_back(mk(1,0,1,0,1,8'h00, 4'hA,4'h3,16'h1234,2'd3, 1,0,0,1,8'h34));
    tv.push_back(mk(1,0,0,1,1,8'h51, 4'h5,4'h1,16'h0000,2'd1, 1,0,0,0,8'h00));
    tv.push_back(mk(1,0,0,0,0,8'h62, 4'h6,4'h2,16'h0000,2'd1, 1,0,1,1,8'h02));
    tv.push_back(mk(1,0,1,1,0,8'h00, 4'h6,4'h2,16'h0000,2'd1, 1,0,0,0,8'h02));
    tv.push_back(mk(1,0,0,1,0,8'hA3, 4'hA,4'h3,16'h0000,2'd3, 0,1,0,0,8'h03));
    tv.push_back(mk(1,1,1,1,0,8'h00, 4'h0,4'h0,16'h0000,2'd0, 0,0,0,0,8'h00));
    tv.push_back(mk(1,1,0,1,0,8'h51, 4'h0,4'h0,16'h0000,2'd0, 0,0,0,0,8'h00));
    tv.push_back(mk(1,0,1,1,0,8'h00, 4'h0,4'h0,16'h0000,2'd0, 0,0,0,0,8'h00));
    tv.push_back(mk(1,0,0,1,0,8'h7F, 4'h7,4'hF,16'h0000,2'd3, 0,1,0,0,8'h0F));
    tv.push_back(mk(1,0,0,1,0,8'h55, 4'h7,4'hF,16'h0055,2'd3, 0,1,0,0,8'h0F));
    tv.push_back(mk(0,0,1,1,0,8'h00, 4'h0,4'h0,16'h0000,2'd0, 0,0,0,0,8'h00));
    tv.push_back(mk(1,0,0,1,0,8'hC1, 4'hC,4'h1,16'h0000,2'd2, 0,1,0,0,8'h01));
    tv.push_back(mk(1,0,0,1,0,8'h9D, 4'hC,4'h1,16'h009D,2'd2, 1,0,0,0,8'h01));
    tv.push_back(mk(1,0,0,1,0,8'h30, 4'h3,4'h0,16'h0000,2'd2, 0,1,0,0,8'h00));
    tv.push_back(mk(1,0,0,0,0,8'hEE, 4'h3,4'h0,16'h00EE,2'd2, 1,0,1,1,8'h00));

    foreach (tv[i]) begin
      apply(tv[i].c, tv[i].fl, tv[i].ii, tv[i].io, tv[i].s, tv[i].b);
      chk($sformatf("v%0d.opcode", i),  32'(opc_b),       32'(tv[i].opc));
      chk($sformatf("v%0d.imm", i),     32'(imm_b),       32'(tv[i].imm));
      chk($sformatf("v%0d.operand", i), 32'(opnd_b),      32'(tv[i].opnd));
      chk($sformatf("v%0d.len", i),     32'(len_b),       32'(tv[i].len));
      chk($sformatf("v%0d.valid", i),   32'(vld_b),       32'(tv[i].vld));
      chk($sformatf("v%0d.fetch", i),   32'(fm_b),        32'(tv[i].fm));
      chk($sformatf("v%0d.conflict", i),32'(cf_b),        32'(tv[i].cf));
      chk($sformatf("v%0d.bus_oe", i),  32'(ifb.bus_oe),  32'(tv[i].oe));
      chk($sformatf("v%0d.bus_out", i), 32'(ifb.bus_out), 32'(tv[i].bo));
    end

    // MAX_BYTES=2 clamps a 4-byte map entry to 2 bytes; the default build sees 1-byte opcodes.
    apply(1,1,1,1,0,8'h00);
    chk("c.flush.valid", 32'(vld_c), 32'h0);
    apply(1,0,0,1,0,8'hA3);
    chk("c.a3.fetch", 32'(fm_c), 32'h1);
    chk("c.a3.valid", 32'(vld_c), 32'h0);
    chk("c.a3.len",   32'(len_c), 32'h2);
    chk("a.a3.valid", 32'(vld_a), 32'h1);
    chk("a.a3.len",   32'(len_a), 32'h1);
    apply(1,0,0,1,0,8'h77);
    chk("c.77.valid",   32'(vld_c),  32'h1);
    chk("c.77.fetch",   32'(fm_c),   32'h0);
    chk("c.77.len",     32'(len_c),  32'h2);
    chk("c.77.operand", 32'(opnd_c), 32'h77);
    chk("a.77.opcode",  32'(opc_a),  32'h7);
    chk("a.77.operand", 32'(opnd_a), 32'h0);
    apply(1,0,1,0,1,8'h00);
    chk("c.sel1.bus_out", 32'(ifc.bus_out), 32'h77);
    chk("a.sel1.bus_out", 32'(ifa.bus_out), 32'h00);
    for (int d = 0; d < 3; d++) cmp_model(d);

    // Randomized phase, all three configurations against the model.
    for (int n = 0; n < 500; n++) begin
      logic c, fl, ii, io; logic [1:0] s; logic [7:0] b; int pick;
      c  = ($urandom_range(0, 99) >= 3);
      fl = ($urandom_range(0, 99) < 5);
      ii = ($urandom_range(0, 1) == 1);
      io = ($urandom_range(0, 99) >= 30);
      s  = 2'($urandom_range(0, 3));
      b  = 8'($urandom);
      pick = $urandom_range(0, 9);
      if (pick < 5) b[7:4] = (pick == 0) ? 4'hA : (pick == 1) ? 4'h3 : (pick == 2) ? 4'h7 :
                             (pick == 3) ? 4'hC : 4'h4;
      apply(c, fl, ii, io, s, b);
      for (int d = 0; d < 3; d++) cmp_model(d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule

// File: doc/instr_reg_multi.md
Name: instr_reg_multi

Overview:
- Parametrised instruction register for the 8-bit CPU datapath.
- Assembles single- or multi-byte instructions from the shared data bus over successive `ii_n` load cycles.
- Presents opcode, short immediate and extension operand bytes to the control unit, and drives any selected operand field back onto the bus.
- Replaces the fixed 4-bit/4-bit instruction register. The default configuration is cycle-compatible with it.

Parameters:
- DATA_W, 8, bus width in bits.
- OPC_W, 4, opcode width; the opcode is the upper OPC_W bits of byte 0, the short immediate is the remaining low bits.
- MAX_BYTES, 3, maximum instruction length in bytes, 1..4.
- LEN_MAP, all zeros, 2 bits per opcode (2^OPC_W entries, opcode n at bits [2n+1:2n]) giving the extension-byte count; default means every instruction is 1 byte.

Ports:
- clk  input  1  system clock, rising edge.
- clr_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous clear to EMPTY, active-high.
- bus_in  input  DATA_W  bus value sampled on loads.
- bus_out  output  DATA_W  selected operand field, zero-extended.
- bus_oe  output  1  bus drive enable for the top-level bus mux.
- ii_n  input  1  active-low instruction-in: load a byte at the clock edge.
- io_n  input  1  active-low instruction-out: drive the selected field.
- oper_sel  input  max(1,clog2(MAX_BYTES))  0 = short immediate, k = extension byte k.
- opcode  output  OPC_W  registered opcode.
- imm  output  DATA_W-OPC_W  registered short immediate.
- operand  output  (MAX_BYTES-1)*DATA_W  extension bytes; byte 1 occupies bits [DATA_W-1:0] (little-endian).
- instr_len  output  clog2(MAX_BYTES+1)  total bytes of the current instruction.
- instr_valid  output  1  complete instruction held.
- fetch_more  output  1  high in FETCH: the controller must issue further loads.
- conflict  output  1  registered one-cycle pulse when ii_n and io_n were both low.

Behaviour:
- Async reset (clr_n low):
  - State EMPTY.
  - opcode, imm, operand, instr_len, instr_valid, fetch_more and conflict all 0.
  - bus_oe forced 0 while clr_n is low.
- States: EMPTY, FETCH, FULL (2-bit encoding from the package).
- Extension count: ext = min(LEN_MAP[opcode], MAX_BYTES-1).
- Byte-0 load (ii_n low at an edge while in EMPTY or FULL):
  - opcode <= bus_in[DATA_W-1 -: OPC_W]; imm <= low bits.
  - operand cleared to 0; cnt <= 0; instr_len <= ext+1.
  - Next state is FULL if ext==0, else FETCH.
- FETCH (ii_n low at an edge):
  - operand byte (cnt+1) <= bus_in; cnt++.
  - When cnt reaches ext-1, go to FULL.
  - ii_n high holds state indefinitely; there is no timeout.
- Outputs by state:
  - instr_valid = (state==FULL); fetch_more = (state==FETCH). Both registered, so they update on the edge that changes state.
  - opcode and imm are visible from the cycle after the byte-0 load, including during FETCH.
- Latency: a 1-byte instruction is valid the cycle after its ii_n load. An N-byte instruction is valid the cycle after the N-th load.
- Bus drive:
  - bus_oe = ~io_n & clr_n, combinational, independent of state.
  - bus_out is combinational from oper_sel:
    - oper_sel=0 gives {zeros, imm}.
    - oper_sel=k with 1 ≤ k ≤ MAX_BYTES-1 gives operand byte k.
    - oper_sel ≥ MAX_BYTES gives 0.
  - Unloaded bytes read 0 because they are cleared at byte-0 load.
- flush: next edge goes to EMPTY and clears all registered outputs. flush has priority over ii_n in the same cycle, so that byte is discarded.
- ii_n and io_n both low:
  - The load still occurs from bus_in, and bus_out/bus_oe still drive (the top-level mux decides).
  - conflict is set for exactly one cycle after each such edge.
- Reset asserted mid-FETCH: immediate return to reset values; partial bytes are lost.

Decomposition:
- Package instr_reg_pkg holds:
  - state typedef and its encodings;
  - LEN_MAP default constant;
  - width helper functions for sel/len widths;
  - clamp function for ext.
- Sub-module instr_len_decode (combinational opcode → clamped ext and instr_len) is natural. It is reused by the control-unit sequencer for fetch-step counting.

Test Plan:
1. Hold clr_n low with io_n low and bus_in=0xFF -> bus_oe=0, instr_valid=0, opcode=0, operand=0. Release and idle 3 cycles -> all remain 0.
2. Default params; ii_n low one cycle with bus_in=0x2E -> next cycle opcode=0x2, imm=0xE, instr_len=1, instr_valid=1. Then io_n low, oper_sel=0 -> bus_oe=1, bus_out=0x0E.
3. LEN_MAP[0xA]=2; load 0xA3, idle 2 cycles, load 0x34, load 0x12:
   - fetch_more=1 after the first and second loads;
   - instr_valid=1 only after the third load;
   - operand=0x1234, instr_len=3;
   - oper_sel=2 with io_n low gives bus_out=0x12; oper_sel=3 (out of range) gives 0x00.
4. MAX_BYTES=2, LEN_MAP[0xA]=3; load 0xA3, 0x77 -> instr_valid after the second load, instr_len=2, operand=0x77.
5. Flush scenarios:
   - Mid-FETCH (after 0xA3) -> next cycle EMPTY, all outputs 0.
   - flush with ii_n low, bus_in=0x51 -> byte ignored, instr_valid=0.
6. After scenario 3, load 0x51 (1-byte) -> operand=0, oper_sel=1 gives bus_out=0. Then ii_n and io_n low together with bus_in=0x62 -> opcode=0x6, and conflict=1 for exactly one cycle.
